// File: rtl/fir_ctrl_pkg.sv
// fir_ctrl_pkg: shared state type and tap-select width helper for the FIR sequencer
package fir_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, MAC, DONE} seq_state_t;

    function automatic int addr_w(input int taps);
        return (taps > 1) ? $clog2(taps) : 1;
    endfunction

endpackage

// File: rtl/tap_counter.sv
// tap_counter: counts taps 0..TAPS-1 and flags the last one
module tap_counter
    import fir_ctrl_pkg::*;
#(
    parameter int TAPS = 8,
    parameter int W    = addr_w(TAPS)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         last
);

    logic [W-1:0] r_count;

    assign count = r_count;
    assign last  = (r_count == W'(TAPS - 1));

    // Wraps to zero after the last tap, so a non-power-of-2 TAPS never overruns
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_count <= '0;
        else if (clr)
            r_count <= '0;
        else if (en)
            r_count <= last ? '0 : r_count + 1'b1;
    end

endmodule

// File: rtl/fir_tap_sequencer.sv
// fir_tap_sequencer: shifts the delay line, then drives one MAC tap per cycle, then loads the output
module fir_tap_sequencer
    import fir_ctrl_pkg::*;
#(
    parameter int TAPS   = 8,
    parameter int ADDR_W = addr_w(TAPS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              shift_en,
    output logic [ADDR_W-1:0] tap_sel,
    output logic              acc_clr,
    output logic              acc_en,
    output logic              out_en,
    output logic              out_valid,
    output logic              busy
);

    seq_state_t        r_state;
    seq_state_t        w_next;
    logic [ADDR_W-1:0] w_count;
    logic              w_last;
    logic              r_out_valid;

    tap_counter #(.TAPS(TAPS), .W(ADDR_W)) u_tap_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (r_state != MAC),
        .en    (r_state == MAC),
        .count (w_count),
        .last  (w_last)
    );

    assign busy      = (r_state != IDLE);
    assign out_valid = r_out_valid;

    // State register and the one-cycle output-valid pulse following DONE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_out_valid <= (r_state == DONE);
        end
    end

    // Next state and datapath enables; every enable is gated by rst so reset forces them low
    always_comb begin
        w_next   = r_state;
        in_ready = 1'b0;
        shift_en = 1'b0;
        tap_sel  = '0;
        acc_clr  = 1'b0;
        acc_en   = 1'b0;
        out_en   = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = rst;
                shift_en = rst & in_valid;
                if (in_valid)
                    w_next = MAC;
            end
            MAC: begin
                tap_sel = w_count;
                acc_en  = rst;
                acc_clr = rst & (w_count == '0);
                if (w_last)
                    w_next = DONE;
            end
            DONE: begin
                out_en = rst;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// tb_fir_tap_sequencer: timestamp-based reference model checks TAPS=4 and TAPS=1 sequencers every cycle
module tb_fir_tap_sequencer;

    logic clk;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic go = 1'b0;

    logic       in_ready4, shift_en4, acc_clr4, acc_en4, out_en4, out_valid4, busy4;
    logic [1:0] tap_sel4;
    logic       in_ready1, shift_en1, acc_clr1, acc_en1, out_en1, out_valid1, busy1;
    logic [0:0] tap_sel1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int hs4   = 0;
    int hs1   = 0;
    bit hs4_ok = 0;
    bit hs1_ok = 0;

    fir_tap_sequencer #(.TAPS(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4), .shift_en(shift_en4),
        .tap_sel(tap_sel4), .acc_clr(acc_clr4), .acc_en(acc_en4), .out_en(out_en4),
        .out_valid(out_valid4), .busy(busy4)
    );

    fir_tap_sequencer #(.TAPS(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .shift_en(shift_en1),
        .tap_sel(tap_sel1), .acc_clr(acc_clr1), .acc_en(acc_en1), .out_en(out_en1),
        .out_valid(out_valid1), .busy(busy1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s t=%0t got=%0h want=%0h", n, $time, a, e);
        end
    endtask

    // Expected outputs from d = cycles since the last accepted sample (large when none):
    // {in_ready, shift_en, tap_sel, acc_clr, acc_en, out_en, out_valid, busy}
    function automatic logic [8:0] model(input int t, input int d, input logic r, input logic iv);
        logic busy, mac, rdy;
        logic [1:0] ts;
        if (!r) return '0;
        busy = (d >= 1) && (d <= t + 1);
        mac  = (d >= 1) && (d <= t);
        rdy  = !busy;
        ts   = mac ? 2'(d - 1) : 2'd0;
        return {rdy, rdy && iv, ts, d == 1, mac, d == t + 1, d == t + 2, busy};
    endfunction

    function automatic logic [8:0] act4();
        return {in_ready4, shift_en4, tap_sel4, acc_clr4, acc_en4, out_en4, out_valid4, busy4};
    endfunction

    function automatic logic [8:0] act1();
        return {in_ready1, shift_en1, 1'b0, tap_sel1, acc_clr1, acc_en1, out_en1, out_valid1, busy1};
    endfunction

    // Per-cycle compare against the model, then record accepted samples
    always @(negedge clk) begin
        logic [8:0] e4, e1;
        if (go) begin
            e4 = model(4, hs4_ok ? cyc - hs4 : 1000, rst, in_valid);
            e1 = model(1, hs1_ok ? cyc - hs1 : 1000, rst, in_valid);
            chk("model_t4", 32'(act4()), 32'(e4));
            chk("model_t1", 32'(act1()), 32'(e1));
            chk("onehot_t4", 32'($onehot0({shift_en4, acc_en4, out_en4})), 32'd1);
            chk("onehot_t1", 32'($onehot0({shift_en1, acc_en1, out_en1})), 32'd1);
            if (!rst) begin
                hs4_ok = 0;
                hs1_ok = 0;
            end else begin
                if (e4[7]) begin hs4 = cyc; hs4_ok = 1; end
                if (e1[7]) begin hs1 = cyc; hs1_ok = 1; end
            end
            cyc++;
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    logic [8:0] lit4 [7] = '{9'b1_1_00_0_0_0_0_0, 9'b0_0_00_1_1_0_0_1, 9'b0_0_01_0_1_0_0_1,
                             9'b0_0_10_0_1_0_0_1, 9'b0_0_11_0_1_0_0_1, 9'b0_0_00_0_0_1_0_1,
                             9'b1_0_00_0_0_0_1_0};
    logic [8:0] lit1 [4] = '{9'b1_1_00_0_0_0_0_0, 9'b0_0_00_1_1_0_0_1, 9'b0_0_00_0_0_1_0_1,
                             9'b1_0_00_0_0_0_1_0};

    initial begin
        int sh_mask, ov_mask, cnt;
        #1 rst = 1'b0;
        in_valid = 1'b1;
        go = 1'b1;
        // Reset holds everything quiet even with a sample offered
        repeat (3) begin
            @(negedge clk);
            chk("rst_in_ready", 32'(in_ready4), 0);
            chk("rst_shift_en", 32'(shift_en4), 0);
            chk("rst_out_valid", 32'(out_valid4), 0);
            chk("rst_busy", 32'(busy4), 0);
        end
        next();
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("release_in_ready4", 32'(in_ready4), 1);
        chk("release_in_ready1", 32'(in_ready1), 1);
        repeat (3) next();
        // Single sample: literal cycle-by-cycle pins for both builds
        in_valid = 1'b1;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            chk($sformatf("single_t4_c%0d", c), 32'(act4()), 32'(lit4[c]));
            if (c < 4) chk($sformatf("single_t1_c%0d", c), 32'(act1()), 32'(lit1[c]));
            next();
            in_valid = 1'b0;
        end
        repeat (4) next();
        // Held in_valid: shifts at 0,6,12 and out_valid at 6,12,18
        sh_mask = 0;
        ov_mask = 0;
        for (int c = 0; c < 20; c++) begin
            in_valid = (c < 18);
            @(negedge clk);
            if (shift_en4) sh_mask |= (1 << c);
            if (out_valid4) ov_mask |= (1 << c);
            next();
        end
        in_valid = 1'b0;
        chk("held_shift_mask", 32'(sh_mask), 32'h0000_1041);
        chk("held_ov_mask", 32'(ov_mask), 32'h0004_1040);
        repeat (4) next();
        // Reset in the middle of a sample
        in_valid = 1'b1;
        next();
        in_valid = 1'b0;
        next();
        next();
        @(negedge clk);
        chk("mid_before_tap", 32'(tap_sel4), 2);
        next();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_busy", 32'(busy4), 0);
        chk("mid_acc_en", 32'(acc_en4), 0);
        next();
        rst = 1'b1;
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            cnt += int'(out_en4) + int'(out_valid4);
            next();
        end
        chk("mid_no_output", 32'(cnt), 0);
        in_valid = 1'b1;
        next();
        in_valid = 1'b0;
        @(negedge clk);
        chk("restart_tap", 32'(tap_sel4), 0);
        chk("restart_clr", 32'(acc_clr4), 1);
        repeat (6) next();
        // Randomized traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) != 0);
            in_valid = ($urandom_range(0, 2) != 0);
            next();
        end
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (8) next();
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
